// File: rtl/pool1_pkg.sv
// pool1_pkg: shared constants and types for the pool1 max-pooling stage.
//   DATA_W / ADDR_W      : sample and index widths
//   POOL_INPUT_SIZE      : conv1 samples per filter (even)
//   POOL_OUTPUT_SIZE     : pooled samples per filter
//   POOL_FILTER          : number of filters
//   state_e              : pooling FSM encoding
package pool1_pkg;
  localparam int DATA_W           = 16;
  localparam int ADDR_W           = 5;
  localparam int POOL_INPUT_SIZE  = 22;
  localparam int POOL_OUTPUT_SIZE = 11;
  localparam int POOL_FILTER      = 20;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic [ADDR_W-1:0]        idx_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;
endpackage

// File: rtl/pool1_if.sv
// pool1_if: conv1 read port + pool1 write port + control of the pool1 stage.
//   start                     : level run enable (master -> slave)
//   input_filter/input_addra  : conv1 read address (slave -> master)
//   idata                     : conv1 read data, 1 cycle after address
//   output_filter/output_addra/odata/owe : pooled write
//   done                      : sticky completion flag
interface pool1_if;
  import pool1_pkg::*;

  logic    start;
  idx_t    input_filter;
  idx_t    input_addra;
  sample_t idata;
  idx_t    output_filter;
  idx_t    output_addra;
  sample_t odata;
  logic    owe;
  logic    done;

  modport slave (
    input  start, idata,
    output input_filter, input_addra, output_filter, output_addra, odata, owe, done
  );

  modport master (
    output start, idata,
    input  input_filter, input_addra, output_filter, output_addra, odata, owe, done
  );
endinterface

// File: rtl/pool1_max_unit.sv
// pool1_max_unit: pairs returning conv1 samples and emits the registered max.
//   Optional macro POOL1_RELU_EN clamps negative results to zero.
//   rd_vld_i    : idata_i carries a valid read this cycle
//   rd_pos_i    : position of that read (bit 0 selects hold vs compare)
//   rd_filt_i   : filter of that read
//   idata_i     : conv1 read data
//   odata_o/owe_o/oaddr_o/ofilt_o : registered pooled write
module pool1_max_unit
  import pool1_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    rd_vld_i,
  input  idx_t    rd_pos_i,
  input  idx_t    rd_filt_i,
  input  sample_t idata_i,
  output sample_t odata_o,
  output logic    owe_o,
  output idx_t    oaddr_o,
  output idx_t    ofilt_o
);
  sample_t hold_q;
  sample_t odata_q;
  logic    owe_q;
  idx_t    oaddr_q, ofilt_q;
  sample_t max_d, res_d;

  // Strict greater-than so a tie keeps the even (held) sample.
  always_comb begin
    max_d = (idata_i > hold_q) ? idata_i : hold_q;
`ifdef POOL1_RELU_EN
    res_d = (max_d < 0) ? '0 : max_d;
`else
    res_d = max_d;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q  <= '0;
      odata_q <= '0;
      owe_q   <= 1'b0;
      oaddr_q <= '0;
      ofilt_q <= '0;
    end else begin
      owe_q <= 1'b0;
      if (rd_vld_i) begin
        if (!rd_pos_i[0]) begin
          hold_q <= idata_i;
        end else begin
          odata_q <= res_d;
          owe_q   <= 1'b1;
          oaddr_q <= rd_pos_i >> 1;
          ofilt_q <= rd_filt_i;
        end
      end
    end
  end

  assign odata_o = odata_q;
  assign owe_o   = owe_q;
  assign oaddr_o = oaddr_q;
  assign ofilt_o = ofilt_q;
endmodule

// File: rtl/pool1_top.sv
// pool1_top: max-pool (kernel 2, stride 2) of conv1 results into pool1 memory.
//   Optional macro POOL1_RELU_EN (see pool1_max_unit) applies ReLU.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : pool1_if.slave (start, conv1 read port, pool1 write port, done)
// Reads are issued one per cycle while start is high, filter-major. The read
// address is registered, so a read issued this cycle returns next cycle; the
// issue flag and address travel alongside it to tag the returning data.
module pool1_top
  import pool1_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  pool1_if.slave  bus
);
  localparam idx_t LAST_POS  = idx_t'(POOL_INPUT_SIZE - 1);
  localparam idx_t LAST_FILT = idx_t'(POOL_FILTER - 1);

  state_e state_q;
  idx_t   filt_q, pos_q;
  logic   rd_vld_q;
  idx_t   rd_pos_q, rd_filt_q;
  logic   done_q;
  logic   issue;

  assign issue = (state_q == S_RUN) && bus.start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      filt_q    <= '0;
      pos_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_pos_q  <= '0;
      rd_filt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      rd_vld_q <= issue;
      if (issue) begin
        rd_pos_q  <= pos_q;
        rd_filt_q <= filt_q;
      end
      case (state_q)
        S_IDLE: if (bus.start) state_q <= S_RUN;
        S_RUN: begin
          if (bus.start) begin
            // Address stays on the final sample after the last issue.
            if (filt_q == LAST_FILT && pos_q == LAST_POS) begin
              state_q <= S_DRAIN;
            end else if (pos_q == LAST_POS) begin
              pos_q  <= '0;
              filt_q <= filt_q + 1'b1;
            end else begin
              pos_q <= pos_q + 1'b1;
            end
          end
        end
        // Last read returns here; its write registers together with done.
        S_DRAIN: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_DONE:  ;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  pool1_max_unit u_max (
    .clk       (clk),
    .rst       (rst),
    .rd_vld_i  (rd_vld_q),
    .rd_pos_i  (rd_pos_q),
    .rd_filt_i (rd_filt_q),
    .idata_i   (bus.idata),
    .odata_o   (bus.odata),
    .owe_o     (bus.owe),
    .oaddr_o   (bus.output_addra),
    .ofilt_o   (bus.output_filter)
  );

  assign bus.input_filter = filt_q;
  assign bus.input_addra  = pos_q;
  assign bus.done         = done_q;
endmodule

// File: tb/tb_pool1_top.sv
// tb_pool1_top: directed scoreboard bench for pool1_top.
module tb_pool1_top;
  import pool1_pkg::*;

  logic clk;
  logic rst;
  pool1_if bus();

  pool1_top dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [4:0]         f;
    logic [4:0]         a;
    logic signed [15:0] d;
  } exp_t;

  logic signed [15:0] mem [0:POOL_FILTER-1][0:POOL_INPUT_SIZE-1];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   wr_cnt = 0;

  // Synchronous conv1 memory: data valid one cycle after the address.
  always @(posedge clk) begin
    if (int'(bus.input_filter) < POOL_FILTER && int'(bus.input_addra) < POOL_INPUT_SIZE)
      bus.idata <= mem[int'(bus.input_filter)][int'(bus.input_addra)];
    else
      bus.idata <= '0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [15:0] pool_ref(input int f, input int k);
    logic signed [15:0] a, b, m;
    a = mem[f][2*k];
    b = mem[f][2*k+1];
    m = (b > a) ? b : a;
`ifdef POOL1_RELU_EN
    if (m < 0) m = '0;
`endif
    return m;
  endfunction

  task automatic push_all();
    exp_t e;
    for (int f = 0; f < POOL_FILTER; f++)
      for (int k = 0; k < POOL_OUTPUT_SIZE; k++) begin
        e.f = 5'(f);
        e.a = 5'(k);
        e.d = pool_ref(f, k);
        sb.push_back(e);
      end
  endtask

  // Write monitor: every owe must match the head of the scoreboard, and
  // done must be high exactly when the final expected write appears.
  always @(negedge clk) begin
    if (!rst && bus.owe) begin
      exp_t e;
      chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("wr_filter", 32'(bus.output_filter), 32'(e.f));
        chk("wr_addr", 32'(bus.output_addra), 32'(e.a));
        chk("wr_data", 32'(bus.odata), 32'(e.d));
        chk("done_vs_last", 32'(bus.done), 32'(sb.size() == 0));
      end
      wr_cnt++;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    wr_cnt = 0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run(input string tag, input bit toggle);
    int cyc;
    push_all();
    wr_cnt = 0;
    cyc = 0;
    bus.start = 1'b1;
    while (!bus.done && cyc < 3000) begin
      if (toggle) bus.start = ((cyc / 3) % 2) == 0;
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_wr_cnt"}, 32'(wr_cnt), 32'd220);
    chk({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [4:0] hf, ha;
    bit owe_seen;
    rst = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_owe", 32'(bus.owe), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_odata", 32'(bus.odata), 32'd0);
    chk("rst_in_addr", {22'd0, bus.input_filter, bus.input_addra}, 32'd0);
    chk("rst_out_addr", {22'd0, bus.output_filter, bus.output_addra}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Random data with directed pairs: {3,7}, {-2,-9}, tie at min, {max,-1}.
    for (int f = 0; f < POOL_FILTER; f++)
      for (int p = 0; p < POOL_INPUT_SIZE; p++)
        mem[f][p] = 16'($urandom);
    mem[0][0] = 16'sd3;     mem[0][1] = 16'sd7;
    mem[0][2] = -16'sd2;    mem[0][3] = -16'sd9;
    mem[1][0] = -16'sd32768; mem[1][1] = -16'sd32768;
    mem[1][2] = 16'sd32767; mem[1][3] = -16'sd1;
`ifdef POOL1_RELU_EN
    chk("ref_neg_pair", 32'(pool_ref(0, 1)), 32'd0);
    chk("ref_min_tie", 32'(pool_ref(1, 0)), 32'd0);
`else
    chk("ref_neg_pair", 32'(pool_ref(0, 1)), 32'hFFFF_FFFE);
    chk("ref_min_tie", 32'(pool_ref(1, 0)), 32'hFFFF_8000);
`endif
    chk("ref_max_pair", 32'(pool_ref(1, 1)), 32'd32767);
    run("rand", 1'b0);

    // start held after done: nothing moves, no writes.
    hf = bus.input_filter;
    ha = bus.input_addra;
    owe_seen = 1'b0;
    bus.start = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      owe_seen |= bus.owe;
    end
    chk("post_done_owe", 32'(owe_seen), 32'd0);
    chk("post_done_addr", {22'd0, bus.input_filter, bus.input_addra}, {22'd0, hf, ha});
    chk("post_done_sticky", 32'(bus.done), 32'd1);

    for (int f = 0; f < POOL_FILTER; f++)
      for (int p = 0; p < POOL_INPUT_SIZE; p++)
        mem[f][p] = 16'(f * 100 + p);
    chk("ref_ramp", 32'(pool_ref(7, 4)), 32'd709);

    do_reset();
    run("ramp", 1'b0);

    do_reset();
    run("toggle", 1'b1);

    // Abort part way through, then a full clean rerun.
    do_reset();
    push_all();
    bus.start = 1'b1;
    for (int c = 0; c < 1000 && wr_cnt < 57; c++) begin
      @(posedge clk); #1;
    end
    chk("abort_reached", 32'(wr_cnt >= 57), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_owe", 32'(bus.owe), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_odata", 32'(bus.odata), 32'd0);
    chk("abort_addr", {22'd0, bus.input_filter, bus.input_addra}, 32'd0);
    chk("abort_oaddr", {22'd0, bus.output_filter, bus.output_addra}, 32'd0);
    bus.start = 1'b0;
    sb.delete();
    wr_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run("rerun", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
